// File: rtl/led_frame_loader_if.sv
// Host-side write/start port and LED-driver pins of led_frame_loader.
// master: host logic (drives writes/start, watches status and pins).
// slave : the loader itself.
interface led_frame_loader_if #(
    parameter int NCOLS = 8
) ();
    localparam int AW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [7:0]    frame_cnt;
    logic          dclk_o;
    logic          din_o;
    logic          strobe_o;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  busy, done, frame_cnt, dclk_o, din_o, strobe_o
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output busy, done, frame_cnt, dclk_o, din_o, strobe_o
    );
endinterface

// File: rtl/led_frame_loader.sv
// led_frame_loader: stages an NCOLS-byte frame written column by column and,
// on request, shifts it MSB first into the LED matrix driver chain using
// din_o/dclk_o, then pulses strobe_o so display bit j equals frame bit j.
// DIV sets the clk cycles per dclk phase and per strobe phase (1..255).
// Optional feature: define LED_LOADER_AUTOSTART_EN so that a write to the
// last column queues a transfer automatically (pending flag).
module led_frame_loader #(
    parameter int NCOLS = 8,
    parameter int DIV   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    led_frame_loader_if.slave  bus
);
    localparam int          NLEDS = 8 * NCOLS;
    localparam int          AW    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int          CW    = (NLEDS > 1) ? $clog2(NLEDS) : 1;
    localparam logic [7:0]  TMAX  = 8'(DIV - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NLEDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIT_LO = 3'd1,
        BIT_HI = 3'd2,
        STROBE = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic [7:0]         timer_q,     timer_d;
    logic [CW-1:0]      bitcnt_q,    bitcnt_d;
    logic [NLEDS-1:0]   frame_q,     frame_d;
    logic [NLEDS-1:0]   shift_q,     shift_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               dclk_q,      dclk_d;
    logic               din_q,       din_d;
    logic               strobe_q,    strobe_d;

    logic               wr_hit;
    logic               last_col_wr;
    logic               start_req;
    logic               accept;
    logic               tick;

`ifdef LED_LOADER_AUTOSTART_EN
    logic               pending_q,   pending_d;
`endif

    // Staging-buffer write decode; out-of-range columns are dropped.
    always_comb begin
        wr_hit      = bus.wr_en && (32'(bus.wr_addr) < 32'(NCOLS));
        last_col_wr = wr_hit && (bus.wr_addr == AW'(NCOLS - 1));
        frame_d     = frame_q;
        if (wr_hit) begin
            frame_d[{bus.wr_addr, 3'b000} +: 8] = bus.wr_data;
        end
    end

`ifdef LED_LOADER_AUTOSTART_EN
    // Pending request: set by a last-column write, cleared on acceptance;
    // a write landing in the acceptance cycle re-arms it for the next frame.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b0;
        end
        if (last_col_wr) begin
            pending_d = 1'b1;
        end
    end

    assign start_req = bus.start | pending_q;
`else
    assign start_req = bus.start;
`endif

    // Next-state, phase timer, bit counter and snapshot logic.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
        accept      = 1'b0;
        tick        = (timer_q == 8'd0);

        case (state_q)
            IDLE: begin
                timer_d = TMAX;
                if (start_req) begin
                    // Snapshot uses the pre-write staging value.
                    accept   = 1'b1;
                    shift_d  = frame_q;
                    bitcnt_d = LAST_BIT;
                    state_d  = BIT_LO;
                end
            end
            BIT_LO: begin
                if (tick) begin
                    state_d = BIT_HI;
                    timer_d = TMAX;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            BIT_HI: begin
                if (tick) begin
                    timer_d = TMAX;
                    if (bitcnt_q == '0) begin
                        state_d = STROBE;
                    end else begin
                        bitcnt_d = bitcnt_q - 1'b1;
                        state_d  = BIT_LO;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            STROBE: begin
                if (tick) begin
                    state_d = FIN;
                    timer_d = TMAX;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            FIN: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                timer_d     = TMAX;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = TMAX;
            end
        endcase
    end

    // Pin values are derived from the upcoming state so the registered pins
    // line up with the state they belong to.
    always_comb begin
        dclk_d   = (state_d == BIT_HI);
        strobe_d = (state_d == STROBE);
        din_d    = 1'b0;
        if ((state_d == BIT_LO) || (state_d == BIT_HI)) begin
            din_d = shift_d[bitcnt_d];
        end
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= TMAX;
            bitcnt_q    <= '0;
            frame_q     <= '0;
            shift_q     <= '0;
            frame_cnt_q <= 8'd0;
            dclk_q      <= 1'b0;
            din_q       <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            frame_q     <= frame_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
            dclk_q      <= dclk_d;
            din_q       <= din_d;
            strobe_q    <= strobe_d;
        end
    end

`ifdef LED_LOADER_AUTOSTART_EN
    // Pending-request register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`endif

    assign bus.busy      = (state_q == BIT_LO) || (state_q == BIT_HI) ||
                           (state_q == STROBE);
    assign bus.done      = (state_q == FIN);
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.dclk_o    = dclk_q;
    assign bus.din_o     = din_q;
    assign bus.strobe_o  = strobe_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader: one DIV=1 and one DIV=3 instance,
// a behavioural model of the driver chain, hand-computed expectations.
module tb_led_frame_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst3_n;

    led_frame_loader_if #(.NCOLS(8)) b1 ();
    led_frame_loader_if #(.NCOLS(8)) b3 ();

    led_frame_loader #(.NCOLS(8), .DIV(1)) dut  (.clk(clk), .rst_n(rst1_n), .bus(b1));
    led_frame_loader #(.NCOLS(8), .DIV(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

    int n_cmp;
    int n_err;

    // results of the last transfer
    int          r_busy, r_rises, r_strobe, r_done, r_hirun;
    logic        r_first;
    logic [63:0] r_vbuf, r_disp;
    logic [7:0]  r_cnt_pre;

    int          cnt1;
    logic [63:0] f2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s3, input logic we, input logic [2:0] a,
                         input logic [7:0] d, input logic st);
        if (s3) begin
            b3.wr_en = we; b3.wr_addr = a; b3.wr_data = d; b3.start = st;
        end else begin
            b1.wr_en = we; b1.wr_addr = a; b1.wr_data = d; b1.start = st;
        end
    endtask

    task automatic wr(input bit s3, input int col, input logic [7:0] d);
        drive(s3, 1'b1, 3'(col), d, 1'b0);
        step();
        drive(s3, 1'b0, 3'd0, 8'd0, 1'b0);
    endtask

    // {busy, done, dclk, din, strobe, frame_cnt}
    function automatic logic [12:0] outs(input bit s3);
        if (s3) return {b3.busy, b3.done, b3.dclk_o, b3.din_o, b3.strobe_o, b3.frame_cnt};
        return {b1.busy, b1.done, b1.dclk_o, b1.din_o, b1.strobe_o, b1.frame_cnt};
    endfunction

    // Runs one transfer, modelling the driver chain (shift toward higher
    // index on dclk rise, latch on strobe rise). wr_at == -1 writes in the
    // start cycle; rst_at >= 0 drops reset in that busy cycle.
    // Returns in the cycle after FIN (or after the budget expires).
    task automatic xfer(input bit s3, input bit do_start, input int start_at,
                        input int wr_at, input int wr_col, input logic [7:0] wr_val,
                        input int rst_at, input int budget);
        logic [12:0] o;
        logic pd, ps;
        int run;
        r_busy = 0; r_rises = 0; r_strobe = 0; r_done = 0; r_hirun = 0;
        r_first = 1'b0; r_vbuf = '0; r_disp = '0; r_cnt_pre = '0;
        if (do_start) begin
            drive(s3, wr_at == -1, 3'(wr_col), wr_val, 1'b1);
            step();
            drive(s3, 1'b0, 3'd0, 8'd0, 1'b0);
        end
        pd = 1'b0; ps = 1'b0; run = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            o = outs(s3);
            if (cyc == 0) r_first = o[12];
            if (o[12]) r_busy++;
            if (o[10]) begin
                run++;
                if (run > r_hirun) r_hirun = run;
                if (!pd) begin
                    r_rises++;
                    r_vbuf = {r_vbuf[62:0], o[9]};
                end
            end else begin
                run = 0;
            end
            pd = o[10];
            if (o[8]) r_strobe++;
            if (o[8] && !ps) r_disp = r_vbuf;
            ps = o[8];
            if (o[11]) begin
                r_done++;
                break;
            end
            drive(s3, cyc == wr_at, 3'(wr_col), wr_val, cyc == start_at);
            if (rst_at >= 0 && cyc == rst_at) begin
                r_cnt_pre = o[7:0];
                if (s3) rst3_n = 1'b0; else rst1_n = 1'b0;
                #2;
                chk("rst_async_outs", 64'(outs(s3)), 64'd0);
            end
            if (rst_at >= 0 && cyc == rst_at + 2) begin
                if (s3) rst3_n = 1'b1; else rst1_n = 1'b1;
            end
            step();
        end
        drive(s3, 1'b0, 3'd0, 8'd0, 1'b0);
        step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; cnt1 = 0;
        rst1_n = 1'b0; rst3_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
        repeat (3) step();
        chk("rst_outs_div1", 64'(outs(1'b0)), 64'd0);
        chk("rst_outs_div3", 64'(outs(1'b1)), 64'd0);
        rst1_n = 1'b1; rst3_n = 1'b1;
        step();
        chk("idle_outs", 64'(outs(1'b0)), 64'd0);

        // empty buffer after reset
        xfer(1'b0, 1'b1, -1, -2, 0, 8'd0, -1, 300);
        cnt1++;
        chk("empty_done", 64'(r_done), 64'd1);
        chk("empty_bits", r_vbuf, 64'd0);
        chk("empty_rises", 64'(r_rises), 64'd64);
        chk("empty_cnt", 64'(b1.frame_cnt), 64'(cnt1));

        // single frame, DIV=1
        f2 = 64'h0123456789ABCDEF;
        for (int i = 0; i < 8; i++) wr(1'b0, i, f2[8*i +: 8]);
`ifdef LED_LOADER_AUTOSTART_EN
        chk("auto_accept_cycle_busy", 64'(b1.busy), 64'd0);
        step();
        xfer(1'b0, 1'b0, -1, -2, 0, 8'd0, -1, 300);
`else
        step();
        chk("no_autostart", 64'(b1.busy), 64'd0);
        xfer(1'b0, 1'b1, -1, -2, 0, 8'd0, -1, 300);
`endif
        cnt1++;
        chk("f2_first_busy", 64'(r_first), 64'd1);
        chk("f2_bits", r_vbuf, 64'h0123456789ABCDEF);
        chk("f2_display", r_disp, 64'h0123456789ABCDEF);
        chk("f2_rises", 64'(r_rises), 64'd64);
        chk("f2_strobe", 64'(r_strobe), 64'd1);
        chk("f2_busy", 64'(r_busy), 64'd129);
        chk("f2_dclk_hi", 64'(r_hirun), 64'd1);
        chk("f2_done", 64'(r_done), 64'd1);
        chk("f2_cnt", 64'(b1.frame_cnt), 64'(cnt1));

        // start during busy is dropped
        xfer(1'b0, 1'b1, 40, -2, 0, 8'd0, -1, 300);
        cnt1++;
        chk("sdb_busy", 64'(r_busy), 64'd129);
        chk("sdb_bits", r_vbuf, 64'h0123456789ABCDEF);
        step();
        chk("sdb_no_requeue", 64'(b1.busy), 64'd0);
        chk("sdb_cnt", 64'(b1.frame_cnt), 64'(cnt1));

        // write with start in the same cycle: pre-write snapshot
        xfer(1'b0, 1'b1, -1, -1, 0, 8'h5A, -1, 300);
        cnt1++;
        chk("same_cyc_snap", r_vbuf, 64'h0123456789ABCDEF);
        xfer(1'b0, 1'b1, -1, -2, 0, 8'd0, -1, 300);
        cnt1++;
        chk("same_cyc_next", r_vbuf, 64'h0123456789ABCD5A);

        // write during busy does not touch the in-flight frame
        for (int i = 0; i < 8; i++) wr(1'b0, i, 8'h00);
`ifdef LED_LOADER_AUTOSTART_EN
        step();
        xfer(1'b0, 1'b0, -1, -2, 0, 8'd0, -1, 300);
        cnt1++;
        chk("auto_zero_bits", r_vbuf, 64'd0);
`endif
        xfer(1'b0, 1'b1, -1, 10, 7, 8'hFF, -1, 300);
        cnt1++;
        chk("wdb_cur_bits", r_vbuf, 64'd0);
        chk("wdb_done", 64'(r_done), 64'd1);
`ifdef LED_LOADER_AUTOSTART_EN
        step();
        chk("auto_after_fin", 64'(b1.busy), 64'd1);
        xfer(1'b0, 1'b0, -1, -2, 0, 8'd0, -1, 300);
`else
        xfer(1'b0, 1'b1, -1, -2, 0, 8'd0, -1, 300);
`endif
        cnt1++;
        chk("wdb_next_bits", r_vbuf, 64'hFF00000000000000);
        chk("wdb_cnt", 64'(b1.frame_cnt), 64'(cnt1));

        // DIV=3 full transfer
        wr(1'b1, 0, 8'hA5);
        xfer(1'b1, 1'b1, -1, -2, 0, 8'd0, -1, 500);
        chk("d3_busy", 64'(r_busy), 64'd387);
        chk("d3_rises", 64'(r_rises), 64'd64);
        chk("d3_dclk_hi", 64'(r_hirun), 64'd3);
        chk("d3_strobe", 64'(r_strobe), 64'd3);
        chk("d3_bits", r_vbuf, 64'h00000000000000A5);
        chk("d3_display", r_disp, 64'h00000000000000A5);
        chk("d3_cnt", 64'(b3.frame_cnt), 64'd1);

        // DIV=3 reset at busy cycle 200: abort, no strobe, no done
        xfer(1'b1, 1'b1, -1, -2, 0, 8'd0, 200, 450);
        chk("d3r_busy", 64'(r_busy), 64'd201);
        chk("d3r_strobe", 64'(r_strobe), 64'd0);
        chk("d3r_done", 64'(r_done), 64'd0);
        chk("d3r_cnt_pre", 64'(r_cnt_pre), 64'd1);
        chk("d3r_outs_after", 64'(outs(1'b1)), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
